// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode pipeline stage that reads the register file
// and registers the results into an ID/EX register.
//   - Register file: NREG x XLEN, with one write port (wb_*). Register x0 always
//     reads as zero.
//   - Operand bypass priority: the late-forward sources (fwd_*, index 0 youngest)
//     win over the writeback port, which wins over the register file contents.
//   - Load-use hazard: a consumer of a load's rd that is still in ID/EX is held
//     upstream, and a bubble goes downstream in its place.
//   - flush kills both the ID/EX contents and any instruction offered in the
//     same cycle.
// Ports:
//   clk, rst (synchronous, active-high)
//   in_valid/in_ready, in_pc, in_imm, in_ctrl, in_is_load, in_rs1/rs2/rd : upstream
//   flush                                                                 : kill
//   wb_we, wb_rd, wb_data                                                 : regfile write
//   fwd_valid, fwd_rd, fwd_data                                           : late bypass
//   out_valid/out_ready, out_* payload                                    : downstream (EX)
//   stall_cnt, flush_cnt                                                  : perf counters
// Build option ID_STAGE_PERF_CNT_EN: when defined, the two counters are
// implemented; otherwise both outputs are tied to zero.
module id_stage_pipe #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NFWD   = 2,
  parameter  int CTRL_W = 64,
  localparam int RIDX   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 in_is_load,
  input  logic [RIDX-1:0]      in_rs1,
  input  logic [RIDX-1:0]      in_rs2,
  input  logic [RIDX-1:0]      in_rd,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [RIDX-1:0]      wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RIDX-1:0] fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [RIDX-1:0]      out_rs1_idx,
  output logic [RIDX-1:0]      out_rs2_idx,
  output logic [RIDX-1:0]      out_rd,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 out_is_load,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  logic [XLEN-1:0]   r_regs [NREG];

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_imm, r_rs1_val, r_rs2_val;
  logic [RIDX-1:0]   r_rs1_idx, r_rs2_idx, r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_is_load;

  logic [RIDX-1:0]   w_src  [2];
  logic [XLEN-1:0]   w_opnd [2];
  logic              w_hazard, w_advance, w_accept;

  assign w_src[0] = in_rs1;
  assign w_src[1] = in_rs2;

  // Apply the sources from lowest priority to highest, so later assignments
  // win: regfile, then writeback, then forwards from oldest to youngest
  // (index 0 is applied last), and finally the x0 override.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_opnd[s] = r_regs[w_src[s]];
      if (wb_we && (wb_rd == w_src[s])) w_opnd[s] = wb_data;
      for (int unsigned k = 0; k < NFWD; k++) begin
        if (fwd_valid[NFWD-1-k] &&
            (fwd_rd[(NFWD-1-k)*RIDX +: RIDX] == w_src[s]))
          w_opnd[s] = fwd_data[(NFWD-1-k)*XLEN +: XLEN];
      end
      if (w_src[s] == '0) w_opnd[s] = '0;
    end
  end

  assign w_hazard  = in_valid && r_valid && r_is_load && (r_rd != '0) &&
                     ((r_rd == in_rs1) || (r_rd == in_rs2));
  assign w_advance = !r_valid || out_ready;
  assign in_ready  = flush || (w_advance && !w_hazard);
  assign w_accept  = in_valid && w_advance && !w_hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= in_valid && !w_hazard;
      if (w_accept) begin
        r_pc      <= in_pc;
        r_imm     <= in_imm;
        r_rs1_val <= w_opnd[0];
        r_rs2_val <= w_opnd[1];
        r_rs1_idx <= in_rs1;
        r_rs2_idx <= in_rs2;
        r_rd      <= in_rd;
        r_ctrl    <= in_ctrl;
        r_is_load <= in_is_load;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_rs1_idx = r_rs1_idx;
  assign out_rs2_idx = r_rs2_idx;
  assign out_rd      = r_rd;
  assign out_ctrl    = r_ctrl;
  assign out_is_load = r_is_load;

`ifdef ID_STAGE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush && r_valid)      r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameters: XLEN, 32, datapath width; NREG, 32, architectural registers (power of 2, RIDX = log2(NREG)); NFWD, 2, late-bypass sources; CTRL_W, 64, control-word width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  upstream (IF/ID) handshake.
REQ-005 in_pc  in  XLEN; in_imm  in  XLEN  selected immediate; in_ctrl  in  CTRL_W  control word; in_is_load  in  1.
REQ-006 in_rs1, in_rs2, in_rd  in  RIDX  register indices.
REQ-007 flush  in  1  kill ID/EX contents and any instruction presented this cycle.
REQ-008 wb_we  in  1; wb_rd  in  RIDX; wb_data  in  XLEN  regfile write port.
REQ-009 fwd_valid  in  NFWD; fwd_rd  in  NFWD*RIDX; fwd_data  in  NFWD*XLEN  late bypass, index 0 youngest.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream (EX) handshake.
REQ-011 out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN; out_rs1_idx, out_rs2_idx, out_rd  out  RIDX; out_ctrl  out  CTRL_W; out_is_load  out  1.
REQ-012 stall_cnt, flush_cnt  out  32  performance counters.

Function
REQ-013 Internal regfile NREG x XLEN, written on clk when wb_we and wb_rd != 0; register 0 reads 0 always.
REQ-014 Operand select per source (combinational, priority order): index 0 -> 0; lowest j with fwd_valid[j] and fwd_rd[j] == idx -> fwd_data[j]; wb_we and wb_rd == idx -> wb_data; else regfile.
REQ-015 hazard = in_valid and out_valid and out_is_load and out_rd != 0 and (out_rd == in_rs1 or out_rd == in_rs2).
REQ-016 advance = !out_valid or out_ready; in_ready = flush or (advance and !hazard).
REQ-017 ID/EX register: flush -> out_valid 0; else if advance -> out_valid <= in_valid and !hazard, payload loaded only when in_valid and in_ready; else hold all.
REQ-018 Latency: instruction accepted at edge N appears on outputs after edge N, one cycle.
REQ-019 While out_valid and !out_ready, all out_* stable.
REQ-020 Hazard with advance: bubble (out_valid 0) inserted; instruction held upstream, re-checked next cycle.
REQ-021 Flush plus hazard, flush plus WB write: flush wins for ID/EX; WB write still performed.
REQ-022 Input accepted during flush discarded, never emitted.
REQ-023 Counters wrap 0xFFFFFFFF -> 0; stall_cnt +1 each cycle in_valid and !in_ready; flush_cnt +1 each cycle flush with out_valid 1.

Reset
REQ-024 rst overrides flush, writes, handshakes; takes effect on next edge.
REQ-025 After reset: out_valid 0, all out_* payload 0, regfile all 0, stall_cnt 0, flush_cnt 0.
REQ-026 Reset mid-stall or mid-transfer: in-flight instruction dropped, nothing emitted until new in_valid accepted.

Configuration
REQ-027 Macro ID_STAGE_PERF_CNT_EN: defined -> stall_cnt, flush_cnt counters per REQ-023; undefined -> no counter flops, both outputs tied 0.

Verification
REQ-028 Reset, then in_valid=1, rs1=5, x5=0x10 in regfile, out_ready=1 -> next cycle out_valid=1, out_rs1_val=0x10.
REQ-029 wb_we=1, wb_rd=3, wb_data=0xDEADBEEF same cycle as accept with rs2=3 -> out_rs2_val=0xDEADBEEF; fwd_valid[0]=1, fwd_rd[0]=3, fwd_data[0]=0x1 also -> 0x1.
REQ-030 Load to x7 in ID/EX, next rs1=7 -> in_ready=0 one cycle, one bubble, then instruction emitted; stall_cnt=1 (macro on).
REQ-031 out_ready=0 for 3 cycles, out_valid=1 -> outputs stable, in_ready=0, no overwrite.
REQ-032 flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, flush_cnt=1, flushed input never emitted; wb_rd=0 write -> x0 reads 0.
